sipo_buf_256b_ctrl: RTL and testbench

SIPO_BUF_256B_CTRL -- requirements
Module: sipo_buf_256b_ctrl

---
 rtl/sipo_buf_256b_ctrl_if.sv | 31 +++
 rtl/sipo_buf_256b_ctrl.sv | 113 +++++++++++
 tb/tb_sipo_buf_256b_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sipo_buf_256b_ctrl_if.sv
// Handshake and datapath-control bundle between the SIPO buffer controller
// and its environment (serial source, reader and datapath).
interface sipo_buf_256b_ctrl_if;
    logic       start;
    logic       sin_valid;
    logic       rd_req;
    logic       addrclr;
    logic       sftregclr;
    logic       sften;
    logic       cnten;
    logic       mem_wen;
    logic       mem_ren;
    logic       busy;
    logic       full;
    logic       rd_valid;
    logic       done;
    logic       ovf;
    logic [6:0] word_cnt;

    modport master (
        output start, sin_valid, rd_req,
        input  addrclr, sftregclr, sften, cnten, mem_wen, mem_ren,
               busy, full, rd_valid, done, ovf, word_cnt
    );

    modport slave (
        input  start, sin_valid, rd_req,
        output addrclr, sftregclr, sften, cnten, mem_wen, mem_ren,
               busy, full, rd_valid, done, ovf, word_cnt
    );
endinterface

// File: rtl/sipo_buf_256b_ctrl.sv
// Controller for a 64 x 32-bit serial-in/parallel-out buffer: captures 64
// serial words into memory, then hands them out one per read request.
module sipo_buf_256b_ctrl (
    input  logic                 clk,
    input  logic                 reset,
    sipo_buf_256b_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_WRITE,
        S_RDY,
        S_RD,
        S_RDOUT
    } state_t;

    state_t     r_state;
    logic [4:0] r_bitcnt;
    logic [6:0] r_word_cnt;
    logic       r_ovf;

    logic       w_last_word;
    logic       w_drop;
    logic       w_step;

    assign w_last_word = (r_word_cnt == 7'd63);
    assign w_step      = (r_state == S_WRITE) || (r_state == S_RDOUT);

    // A serial bit offered while no shift is possible is lost and flagged.
    assign w_drop = bus.sin_valid &&
                    ((r_state == S_WRITE) || (r_state == S_RDY) ||
                     (r_state == S_RD)    || (r_state == S_RDOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_bitcnt   <= 5'd0;
            r_word_cnt <= 7'd0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ovf   <= 1'b0;
                        r_state <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_word_cnt <= 7'd0;
                    r_bitcnt   <= 5'd0;
                    r_state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (bus.sin_valid) begin
                        r_bitcnt <= r_bitcnt + 5'd1;
                        if (r_bitcnt == 5'd31) begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_last_word) begin
                        r_word_cnt <= 7'd0;
                        r_state    <= S_RDY;
                    end else begin
                        r_word_cnt <= r_word_cnt + 7'd1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_RDY: begin
                    if (bus.rd_req) begin
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    r_state <= S_RDOUT;
                end
                S_RDOUT: begin
                    if (w_last_word) begin
                        r_word_cnt <= 7'd0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_word_cnt <= r_word_cnt + 7'd1;
                        r_state    <= S_RDY;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Reset forces the datapath clears and masks every other control.
    assign bus.addrclr   = reset || (r_state == S_CLR) || (w_step && w_last_word);
    assign bus.sftregclr = reset || (r_state == S_CLR);
    assign bus.sften     = !reset && (r_state == S_SHIFT) && bus.sin_valid;
    assign bus.cnten     = !reset && w_step && !w_last_word;
    assign bus.mem_wen   = !reset && (r_state == S_WRITE);
    assign bus.mem_ren   = !reset && (r_state == S_RD);
    assign bus.busy      = !reset && (r_state != S_IDLE);
    assign bus.full      = !reset && (r_state == S_RDY);
    assign bus.rd_valid  = !reset && (r_state == S_RDOUT);
    assign bus.done      = !reset && (r_state == S_RDOUT) && w_last_word;
    assign bus.ovf       = !reset && r_ovf;
    assign bus.word_cnt  = reset ? 7'd0 : r_word_cnt;

endmodule

// File: tb/tb_sipo_buf_256b_ctrl.sv
// Directed bench for the SIPO buffer controller: full capture/readout, overflow,
// ignored start, reset during readout, plus per-cycle control invariants.
module tb_sipo_buf_256b_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sipo_buf_256b_ctrl_if bus ();

    sipo_buf_256b_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int last_wen = -1;
    int wen_cnt = 0;
    bit mon_en = 0;
    bit spc_en = 0;
    bit no_rdv = 0;
    logic [5:0] addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Datapath address counter model driven by the controller's clear/increment.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.addrclr) addr <= 6'd0;
        else if (bus.cnten) addr <= addr + 6'd1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("wen_ren_excl", {31'd0, bus.mem_wen & bus.mem_ren}, 32'd0);
            chk("cnten_addrclr_excl", {31'd0, bus.cnten & bus.addrclr}, 32'd0);
            chk("sften_wen_excl", {31'd0, bus.sften & bus.mem_wen}, 32'd0);
            if (bus.mem_wen || bus.mem_ren)
                chk("addr_eq_wordcnt", {26'd0, addr}, {26'd0, bus.word_cnt[5:0]});
            if (bus.mem_wen) begin
                if (spc_en && last_wen >= 0) chk("wen_spacing", cyc - last_wen, 33);
                last_wen = cyc;
                wen_cnt++;
            end
            if (no_rdv) chk("rdv_after_reset", {31'd0, bus.rd_valid}, 32'd0);
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic capture_word(input int w, input bit hold_valid, input bit pulse_start);
        for (int b = 0; b < 32; b++) begin
            bus.sin_valid = 1'b1;
            bus.start = (pulse_start && b == 5);
            #1;
            if (b == 0) chk("sften_shift", {31'd0, bus.sften}, 32'd1);
            if (b == 0 && w == 1 && hold_valid) chk("ovf_after_write", {31'd0, bus.ovf}, 32'd1);
            if (pulse_start && b == 6) begin
                chk("start_ignored_busy", {31'd0, bus.busy}, 32'd1);
                chk("start_ignored_noclr", {31'd0, bus.addrclr}, 32'd0);
                chk("start_ignored_wc", {25'd0, bus.word_cnt}, 32'd10);
            end
            tick();
        end
        bus.start = 1'b0;
        bus.sin_valid = hold_valid;
        #1;
        chk("write_wen", {31'd0, bus.mem_wen}, 32'd1);
        chk("write_sften", {31'd0, bus.sften}, 32'd0);
        chk("write_wc", {25'd0, bus.word_cnt}, w);
        chk("write_cnten", {31'd0, bus.cnten}, (w < 63) ? 32'd1 : 32'd0);
        chk("write_addrclr", {31'd0, bus.addrclr}, (w == 63) ? 32'd1 : 32'd0);
        tick();
    endtask

    task automatic read_word(input int w);
        tick();
        chk("rd_ren", {31'd0, bus.mem_ren}, 32'd1);
        chk("rd_wc", {25'd0, bus.word_cnt}, w);
        tick();
        chk("rdout_valid", {31'd0, bus.rd_valid}, 32'd1);
        chk("rdout_wc", {25'd0, bus.word_cnt}, w);
        chk("rdout_done", {31'd0, bus.done}, (w == 63) ? 32'd1 : 32'd0);
        chk("rdout_cnten", {31'd0, bus.cnten}, (w < 63) ? 32'd1 : 32'd0);
        tick();
        if (w < 63) chk("rdy_full", {31'd0, bus.full}, 32'd1);
        else begin
            chk("end_busy", {31'd0, bus.busy}, 32'd0);
            chk("end_done", {31'd0, bus.done}, 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_full"}, {31'd0, bus.full}, 32'd0);
        chk({tag, "_rdv"}, {31'd0, bus.rd_valid}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_sften"}, {31'd0, bus.sften}, 32'd0);
        chk({tag, "_cnten"}, {31'd0, bus.cnten}, 32'd0);
        chk({tag, "_wen"}, {31'd0, bus.mem_wen}, 32'd0);
        chk({tag, "_ren"}, {31'd0, bus.mem_ren}, 32'd0);
        chk({tag, "_addrclr"}, {31'd0, bus.addrclr}, 32'd1);
        chk({tag, "_sftregclr"}, {31'd0, bus.sftregclr}, 32'd1);
        chk({tag, "_ovf"}, {31'd0, bus.ovf}, 32'd0);
        chk({tag, "_wc"}, {25'd0, bus.word_cnt}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.sin_valid = 1'b1;
        bus.rd_req = 1'b1;
        tick();
        tick();
        check_reset_outputs("rst0");

        // Idle ignores rd_req and sin_valid.
        reset = 1'b0;
        tick();
        mon_en = 1;
        tick();
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_addrclr", {31'd0, bus.addrclr}, 32'd0);
        chk("idle_ovf", {31'd0, bus.ovf}, 32'd0);
        bus.sin_valid = 1'b0;
        bus.rd_req = 1'b0;

        // Clean capture of 64 words.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        chk("clr_addrclr", {31'd0, bus.addrclr}, 32'd1);
        chk("clr_sftregclr", {31'd0, bus.sftregclr}, 32'd1);
        chk("clr_busy", {31'd0, bus.busy}, 32'd1);
        spc_en = 1;
        last_wen = -1;
        wen_cnt = 0;
        tick();
        chk("shift_noclr", {31'd0, bus.addrclr}, 32'd0);
        for (int w = 0; w < 64; w++) capture_word(w, 1'b0, 1'b0);
        spc_en = 0;
        chk("rdy_full0", {31'd0, bus.full}, 32'd1);
        chk("rdy_wc0", {25'd0, bus.word_cnt}, 32'd0);
        chk("rdy_ovf0", {31'd0, bus.ovf}, 32'd0);
        chk("wen_count", wen_cnt, 64);
        tick();
        chk("rdy_wait_full", {31'd0, bus.full}, 32'd1);
        chk("rdy_wait_ren", {31'd0, bus.mem_ren}, 32'd0);

        // Back-to-back readout.
        bus.rd_req = 1'b1;
        for (int w = 0; w < 64; w++) read_word(w);
        bus.rd_req = 1'b0;

        // Capture with sin_valid held high; start pulsed at word 10.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.sin_valid = 1'b1;
        spc_en = 1;
        last_wen = -1;
        for (int w = 0; w < 64; w++) capture_word(w, 1'b1, w == 10);
        spc_en = 0;
        chk("ovf_rdy", {31'd0, bus.ovf}, 32'd1);
        chk("ovf_full", {31'd0, bus.full}, 32'd1);

        // Read 20 words, then reset in RD at word_cnt=20.
        bus.rd_req = 1'b1;
        for (int w = 0; w < 20; w++) read_word(w);
        tick();
        chk("rd20_ren", {31'd0, bus.mem_ren}, 32'd1);
        chk("rd20_wc", {25'd0, bus.word_cnt}, 32'd20);
        reset = 1'b1;
        no_rdv = 1;
        tick();
        check_reset_outputs("rst_rd");
        reset = 1'b0;
        bus.sin_valid = 1'b0;
        tick();
        tick();
        chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("post_rst_ovf", {31'd0, bus.ovf}, 32'd0);

        // Restart capture lands at address 0.
        bus.rd_req = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        capture_word(0, 1'b0, 1'b0);
        chk("restart_addr", {26'd0, addr}, 32'd1);
        chk("restart_wc", {25'd0, bus.word_cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
